// File: rtl/rv32_ctrl_pkg.sv
// Shared control-path definitions for the RV32I pipeline: hazard FSM state
// encodings, default register-select width and the x0 register index.
package rv32_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } ctrl_state_e;

    localparam int REG_SEL_DEF = 5;
    localparam int X0_IDX      = 0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID-stage instruction that reads
// the destination of a load currently in EX. Writes to x0 never create a hazard.
module load_use_detect
    import rv32_ctrl_pkg::*;
#(
    parameter int REG_SEL = REG_SEL_DEF
) (
    input  logic [REG_SEL-1:0] rs1_id,
    input  logic [REG_SEL-1:0] rs2_id,
    input  logic               use_rs1_id,
    input  logic               use_rs2_id,
    input  logic [REG_SEL-1:0] rd_ex,
    input  logic               mem_read_ex,
    output logic               lu
);

    logic rd_live;
    logic hit_rs1;
    logic hit_rs2;

    assign rd_live = mem_read_ex && (rd_ex != REG_SEL'(X0_IDX));
    assign hit_rs1 = use_rs1_id && (rs1_id == rd_ex);
    assign hit_rs2 = use_rs2_id && (rs2_id == rd_ex);
    assign lu      = rd_live && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles,
// MEM redirects, memory-wait freeze and watchdog halt.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_controller
    import rv32_ctrl_pkg::*;
#(
    parameter int REG_SEL   = REG_SEL_DEF,
    parameter int MAX_WAIT  = 15
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_SEL-1:0] rs1_id,
    input  logic [REG_SEL-1:0] rs2_id,
    input  logic               use_rs1_id,
    input  logic               use_rs2_id,
    input  logic [REG_SEL-1:0] rd_ex,
    input  logic               mem_read_ex,
    input  logic               pc_src,
    input  logic               mem_busy,
    output logic               pc_en,
    output logic               stall_ifid,
    output logic               stall_idex,
    output logic               stall_exmem,
    output logic               stall_memwb,
    output logic               flush_ifid,
    output logic               flush_idex,
    output logic               flush_exmem,
    output logic               flush_memwb,
    output logic               halted,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0] perf_lu_stalls,
    output logic [CNT_WIDTH-1:0] perf_mem_stalls,
    output logic [CNT_WIDTH-1:0] perf_flushes,
`endif
    output logic [1:0]         state_o
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    ctrl_state_e    state_q,    state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           lu;

    load_use_detect #(
        .REG_SEL (REG_SEL)
    ) u_lu (
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .use_rs1_id  (use_rs1_id),
        .use_rs2_id  (use_rs2_id),
        .rd_ex       (rd_ex),
        .mem_read_ex (mem_read_ex),
        .lu          (lu)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_en       = 1'b1;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        stall_memwb = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        flush_memwb = 1'b0;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;

        if (state_q == ST_HALT) begin
            pc_en       = 1'b0;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            stall_memwb = 1'b1;
        end else if (mem_busy) begin
            // Freeze the front of the pipe and feed WB a bubble.
            pc_en       = 1'b0;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            flush_memwb = 1'b1;
            if (state_q != ST_WAIT) begin
                state_d    = ST_WAIT;
                wait_cnt_d = WCW'(1);
            end else if (wait_cnt_q == WCW'(MAX_WAIT)) begin
                state_d = ST_HALT;
            end else begin
                wait_cnt_d = wait_cnt_q + WCW'(1);
            end
        end else begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
            if (pc_src) begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
            end else if (lu) begin
                pc_en      = 1'b0;
                stall_ifid = 1'b1;
                flush_idex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign halted  = (state_q == ST_HALT);
    assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    // Each action has a unique flush signature; all are silent in HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_stalls  <= '0;
            perf_mem_stalls <= '0;
            perf_flushes    <= '0;
        end else begin
            if (flush_idex && !flush_ifid) perf_lu_stalls  <= perf_lu_stalls + 1'b1;
            if (flush_memwb)               perf_mem_stalls <= perf_mem_stalls + 1'b1;
            if (flush_exmem)               perf_flushes    <= perf_flushes + 1'b1;
        end
    end
`endif

endmodule
